// File: rtl/reg_file_wr_arbiter_if.sv
// Requester and register-file write bundle shared by the
// two-port write arbiter and its environment.
interface reg_file_wr_arbiter_if;
    logic       req0_valid;
    logic       req0_lock;
    logic [1:0] req0_addr;
    logic [8:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_lock;
    logic [1:0] req1_addr;
    logic [8:0] req1_data;
    logic       req1_ready;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [8:0] wr_data;
    logic       gnt_id;

    modport master (
        output req0_valid, req0_lock, req0_addr, req0_data,
        output req1_valid, req1_lock, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data, gnt_id
    );

    modport slave (
        input  req0_valid, req0_lock, req0_addr, req0_data,
        input  req1_valid, req1_lock, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data, gnt_id
    );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin write-port arbiter with bounded burst lock,
// driving a registered one-cycle write strobe.
module reg_file_wr_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    reg_file_wr_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;
    localparam logic [3:0] BURST = 4'(MAX_BURST);
    localparam bit LOCK_EN = (MAX_BURST > 1);

    logic [1:0] state, state_nxt;
    logic       prio, prio_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       gnt0, gnt1;
    logic       accept;
    logic       win;
    logic       win_lock;
    logic [1:0] win_addr;
    logic [8:0] win_data;
    logic       in_lock;

    assign in_lock = (state == LOCK0) || (state == LOCK1);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            LOCK0: gnt0 = bus.req0_valid;
            LOCK1: gnt1 = bus.req1_valid;
            default: begin
                gnt0 = bus.req0_valid &&
                       (!bus.req1_valid || !prio);
                gnt1 = bus.req1_valid &&
                       (!bus.req0_valid || prio);
            end
        endcase
        // Nothing may be accepted while held in reset.
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign accept = gnt0 | gnt1;
    assign win    = gnt1;

    always_comb begin
        win_lock = bus.req0_lock;
        win_addr = bus.req0_addr;
        win_data = bus.req0_data;
        unique case (1'b1)
            gnt1: begin
                win_lock = bus.req1_lock;
                win_addr = bus.req1_addr;
                win_data = bus.req1_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        cnt_nxt   = cnt;
        unique case (1'b1)
            in_lock: begin
                if (accept && win_lock &&
                    (cnt + 4'd1) != BURST) begin
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
                if (accept) begin
                    prio_nxt = ~win;
                    if (win_lock && LOCK_EN) begin
                        state_nxt = win ? LOCK1 : LOCK0;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= 2'd0;
            bus.wr_data <= 9'd0;
            bus.gnt_id  <= 1'b0;
        end else begin
            bus.wr_en <= accept;
            if (accept) begin
                bus.wr_addr <= win_addr;
                bus.wr_data <= win_data;
                bus.gnt_id  <= win;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Randomized and directed bench for reg_file_wr_arbiter
// against a transaction-level arbitration model.
module tb_reg_file_wr_arbiter;
    localparam int MB = 4;

    logic clk;
    logic rst_n;

    reg_file_wr_arbiter_if bus ();

    reg_file_wr_arbiter #(.MAX_BURST(MB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit         v[2];
    bit         l[2];
    logic [1:0] a[2];
    logic [8:0] d[2];
    bit         pend[2];

    int m_prio, m_owner, m_beats, m_win, obs_gnt;
    logic       exp_wr_en;
    logic [1:0] exp_addr;
    logic [8:0] exp_data;
    logic       exp_gnt;
    logic [8:0] exp_rf[4];
    logic [8:0] dut_rf[4];

    always @(negedge clk)
        if (bus.wr_en) dut_rf[bus.wr_addr] <= bus.wr_data;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic model_reset();
        m_prio    = 0;
        m_owner   = -1;
        m_beats   = 0;
        exp_wr_en = 1'b0;
        exp_addr  = 2'd0;
        exp_data  = 9'd0;
        exp_gnt   = 1'b0;
    endtask

    function automatic int model_win();
        if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
        if (v[0] && v[1]) return m_prio;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic model_update();
        if (m_owner >= 0) begin
            if (m_win < 0 || !l[m_win]) begin
                m_owner = -1;
            end else begin
                m_beats++;
                if (m_beats >= MB) m_owner = -1;
            end
        end else if (m_win >= 0) begin
            m_prio = 1 - m_win;
            if (l[m_win] && MB > 1) begin
                m_owner = m_win;
                m_beats = 1;
            end
        end
        exp_wr_en = (m_win >= 0);
        if (m_win >= 0) begin
            exp_addr = a[m_win];
            exp_data = d[m_win];
            exp_gnt  = 1'(m_win);
        end
    endtask

    task automatic apply();
        bus.req0_valid = v[0];
        bus.req0_lock  = l[0];
        bus.req0_addr  = a[0];
        bus.req0_data  = d[0];
        bus.req1_valid = v[1];
        bus.req1_lock  = l[1];
        bus.req1_addr  = a[1];
        bus.req1_data  = d[1];
    endtask

    task automatic cycle();
        apply();
        @(negedge clk);
        m_win = model_win();
        chk("ready0", 32'(bus.req0_ready), 32'(m_win == 0));
        chk("ready1", 32'(bus.req1_ready), 32'(m_win == 1));
        chk("wr_en", 32'(bus.wr_en), 32'(exp_wr_en));
        chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
        chk("wr_data", 32'(bus.wr_data), 32'(exp_data));
        chk("gnt_id", 32'(bus.gnt_id), 32'(exp_gnt));
        obs_gnt = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
        if (exp_wr_en) exp_rf[exp_addr] = exp_data;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit v0, input bit l0,
                         input int a0, input int d0,
                         input bit v1, input bit l1,
                         input int a1, input int d1);
        v[0] = v0; l[0] = l0; a[0] = 2'(a0); d[0] = 9'(d0);
        v[1] = v1; l[1] = l1; a[1] = 2'(a1); d[1] = 9'(d1);
        cycle();
    endtask

    int rr_seq[4] = '{0, 1, 0, 1};
    int bu_seq[8] = '{0, 0, 0, 0, 1, 0, -1, 1};
    int k0, k1;

    initial begin
        for (int i = 0; i < 4; i++) begin
            exp_rf[i] = 9'd0;
            dut_rf[i] = 9'd0;
        end
        model_reset();
        rst_n = 1'b0;
        v[0] = 1; l[0] = 0; a[0] = 1; d[0] = 3;
        v[1] = 1; l[1] = 0; a[1] = 2; d[1] = 4;
        apply();
        #3;
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_ready1", 32'(bus.req1_ready), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 0, 0, 3, 1, 0, 0, 4);
        chk("rst_first", 32'(obs_gnt), 0);
        drive(0, 0, 0, 0, 1, 0, 0, 4);

        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 13, 1, 0, 2, 117);
            chk("rr_gnt", 32'(obs_gnt), 32'(rr_seq[i]));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rr_reg1", 32'(dut_rf[1]), 13);
        chk("rr_reg2", 32'(dut_rf[2]), 117);

        drive(1, 0, 3, 5, 1, 0, 3, 9);
        chk("col_first", 32'(obs_gnt), 0);
        drive(0, 0, 0, 0, 1, 0, 3, 9);
        chk("col_second", 32'(obs_gnt), 1);
        chk("col_reg3_mid", 32'(dut_rf[3]), 5);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("col_reg3", 32'(dut_rf[3]), 9);

        k0 = 1;
        k1 = 200;
        for (int i = 0; i < 8; i++) begin
            drive(i != 6, 1, 0, k0, 1, 0, 1, k1);
            chk("burst_gnt", 32'(obs_gnt), 32'(bu_seq[i]));
            if (m_win == 0) k0++;
            if (m_win == 1) k1++;
        end

        drive(1, 1, 0, 7, 1, 0, 2, 50);
        chk("rel_lock", 32'(obs_gnt), 0);
        drive(0, 0, 0, 0, 1, 0, 2, 50);
        chk("rel_gap", 32'(obs_gnt), -1);
        drive(0, 0, 0, 0, 1, 0, 2, 50);
        chk("rel_next", 32'(obs_gnt), 1);

        drive(0, 0, 0, 0, 1, 1, 1, 77);
        chk("mid_gnt", 32'(obs_gnt), 1);
        chk("mid_wr_on", 32'(bus.wr_en), 1);
        v[0] = 0;
        apply();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_wr_en", 32'(bus.wr_en), 0);
        chk("mid_wr_data", 32'(bus.wr_data), 0);
        chk("mid_gnt_id", 32'(bus.gnt_id), 0);
        chk("mid_ready1", 32'(bus.req1_ready), 0);
        model_reset();
        #1 rst_n = 1'b1;
        drive(1, 0, 0, 11, 1, 0, 1, 12);
        chk("mid_after", 32'(obs_gnt), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        pend[0] = 0;
        pend[1] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    l[i] = ($urandom_range(0, 2) != 0);
                    a[i] = 2'($urandom);
                    d[i] = 9'($urandom);
                    pend[i] = v[i];
                end
            end
            cycle();
            if (m_win >= 0) pend[m_win] = 0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            chk("rf", 32'(dut_rf[i]), 32'(exp_rf[i]));

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end
endmodule
